// File: rtl/parity_rx_checker.sv
`default_nettype none
// ============================================================================
// parity_rx_checker
// Serial frame receiver (start, DATA_W data LSB first, parity, stop) that
// checks parity and framing. Optional macro PARITY_RX_ERRCNT_EN adds err_count.
// Revision: 1.0 - initial release
// ============================================================================
module parity_rx_checker #(
    parameter int DATA_W     = 4,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rxd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
`ifdef PARITY_RX_ERRCNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int   CNT_W   = $clog2(DATA_W);
    localparam logic ODD_BIT = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_shreg;
    logic                r_par_bit;
    logic                w_last;
    logic                w_par_err;
    logic                w_stop_sample;

    assign w_last        = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_par_err     = (^r_shreg ^ r_par_bit) ^ ODD_BIT;
    assign w_stop_sample = bit_en && (r_state == STOP);
    assign busy          = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bit_en) begin
            case (r_state)
                IDLE:    if (!rxd) w_state_nxt = DATA;
                DATA:    if (w_last) w_state_nxt = PARITY;
                PARITY:  w_state_nxt = STOP;
                STOP:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: every register moves only on a sample strobe, except out_valid
    // which must drop after exactly one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_shreg    <= '0;
            r_par_bit  <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            out_valid <= w_stop_sample;
            if (bit_en) begin
                case (r_state)
                    IDLE: begin
                        if (!rxd) r_cnt <= '0;
                    end
                    DATA: begin
                        r_shreg[r_cnt] <= rxd;
                        if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
                    end
                    PARITY: begin
                        r_par_bit <= rxd;
                    end
                    STOP: begin
                        out_data   <= r_shreg;
                        parity_err <= w_par_err;
                        frame_err  <= ~rxd;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PARITY_RX_ERRCNT_EN
    // One increment per bad frame, even when both error kinds coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'h00;
        end else if (w_stop_sample && (w_par_err || !rxd) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'h01;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_rx_checker.sv
`default_nettype none
// Directed self-checking bench for parity_rx_checker: an even- and an
// odd-parity instance share the same serial stimulus.
module tb_parity_rx_checker;

    logic       clk;
    logic       rst_n;
    logic       bit_en;
    logic       rxd;
    logic [3:0] e_data, o_data;
    logic       e_valid, o_valid;
    logic       e_perr, o_perr;
    logic       e_ferr, o_ferr;
    logic       e_busy, o_busy;
`ifdef PARITY_RX_ERRCNT_EN
    logic [7:0] e_cnt, o_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    logic busy_mid;

    parity_rx_checker #(.DATA_W(4), .ODD_PARITY(0)) dut_even (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rxd(rxd),
        .out_data(e_data), .out_valid(e_valid), .parity_err(e_perr),
        .frame_err(e_ferr), .busy(e_busy)
`ifdef PARITY_RX_ERRCNT_EN
        , .err_count(e_cnt)
`endif
    );

    parity_rx_checker #(.DATA_W(4), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rxd(rxd),
        .out_data(o_data), .out_valid(o_valid), .parity_err(o_perr),
        .frame_err(o_ferr), .busy(o_busy)
`ifdef PARITY_RX_ERRCNT_EN
        , .err_count(o_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (e_valid) pulses++;

    task automatic send_bit(input logic b, input int gap);
        rxd = b; bit_en = 1'b1;
        @(posedge clk); #1;
        bit_en = 1'b0; rxd = 1'b1;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    // Returns 1 time unit after the stop-bit sample edge (the out_valid cycle).
    task automatic send_frame(input logic [3:0] d, input logic p, input logic s, input int gap);
        send_bit(1'b0, gap);
        busy_mid = e_busy;
        for (int i = 0; i < 4; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        rxd = s; bit_en = 1'b1;
        @(posedge clk); #1;
        bit_en = 1'b0; rxd = 1'b1;
    endtask

    task automatic check_frame(input string name, input logic [3:0] d, input logic pe_even,
                               input logic fe);
        n_checks++;
        if (e_valid !== 1'b1 || o_valid !== 1'b1) begin
            n_fail++; $display("FAIL %s valid: got %b/%b expected 1/1", name, e_valid, o_valid);
        end
        n_checks++;
        if (e_data !== d || o_data !== d) begin
            n_fail++; $display("FAIL %s data: got %h/%h expected %h", name, e_data, o_data, d);
        end
        n_checks++;
        if (e_perr !== pe_even || o_perr !== ~pe_even) begin
            n_fail++; $display("FAIL %s parity_err: got even=%b odd=%b expected even=%b odd=%b",
                               name, e_perr, o_perr, pe_even, ~pe_even);
        end
        n_checks++;
        if (e_ferr !== fe || o_ferr !== fe) begin
            n_fail++; $display("FAIL %s frame_err: got %b/%b expected %b", name, e_ferr, o_ferr, fe);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bit_en = 1'b0; rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({e_data, e_valid, e_perr, e_ferr, e_busy} !== 8'h00 ||
            {o_data, o_valid, o_perr, o_ferr, o_busy} !== 8'h00) begin
            n_fail++; $display("FAIL reset_outputs: got %h/%h expected 00",
                               {e_data, e_valid, e_perr, e_ferr, e_busy},
                               {o_data, o_valid, o_perr, o_ferr, o_busy});
        end
`ifdef PARITY_RX_ERRCNT_EN
        n_checks++;
        if (e_cnt !== 8'h00 || o_cnt !== 8'h00) begin
            n_fail++; $display("FAIL reset_err_count: got %h/%h expected 00", e_cnt, o_cnt);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_idle;
        int p0;
        p0 = pulses;
        repeat (5) send_bit(1'b1, 0);
        n_checks++;
        if (e_busy !== 1'b0 || pulses != p0) begin
            n_fail++; $display("FAIL idle_line: got busy=%b pulses=%0d expected busy=0 pulses=%0d",
                               e_busy, pulses, p0);
        end
    endtask

    task automatic test_basic;
        send_frame(4'hB, 1'b1, 1'b1, 0);
        check_frame("good_B", 4'hB, 1'b0, 1'b0);
        n_checks++;
        if (busy_mid !== 1'b1) begin
            n_fail++; $display("FAIL busy_in_frame: got %b expected 1", busy_mid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (e_valid !== 1'b0 || e_data !== 4'hB || e_busy !== 1'b0) begin
            n_fail++; $display("FAIL valid_one_cycle: got valid=%b data=%h busy=%b expected 0/B/0",
                               e_valid, e_data, e_busy);
        end
        send_frame(4'hB, 1'b0, 1'b1, 0);
        check_frame("badpar_B", 4'hB, 1'b1, 1'b0);
        send_frame(4'h0, 1'b0, 1'b0, 0);
        check_frame("framing_0", 4'h0, 1'b0, 1'b1);
        send_frame(4'h3, 1'b1, 1'b1, 0);
        check_frame("odd_ok_3", 4'h3, 1'b1, 1'b0);
        send_frame(4'h3, 1'b0, 1'b1, 0);
        check_frame("odd_bad_3", 4'h3, 1'b0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int p0;
        p0 = pulses;
        send_frame(4'h5, 1'b0, 1'b1, 3);
        check_frame("slow_5", 4'h5, 1'b0, 1'b0);
        n_checks++;
        if (busy_mid !== 1'b1 || e_busy !== 1'b0) begin
            n_fail++; $display("FAIL slow_busy: got mid=%b end=%b expected 1/0", busy_mid, e_busy);
        end
        repeat (3) begin @(posedge clk); #1; end
        send_frame(4'hA, 1'b0, 1'b1, 3);
        check_frame("slow_A", 4'hA, 1'b0, 1'b0);
        repeat (6) begin @(posedge clk); #1; end
        n_checks++;
        if (pulses != p0 + 2 || e_busy !== 1'b0) begin
            n_fail++; $display("FAIL slow_pulses: got %0d busy=%b expected %0d busy=0",
                               pulses - p0, e_busy, 2);
        end
        // Start bit sampled in the out_valid cycle of the previous frame.
        send_frame(4'h6, 1'b0, 1'b1, 0);
        check_frame("fast_6", 4'h6, 1'b0, 1'b0);
        send_frame(4'h7, 1'b0, 1'b1, 0);
        check_frame("fast_7", 4'h7, 1'b1, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_abort;
        int p0;
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b1, 1);
        p0 = pulses;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (e_busy !== 1'b0 || e_data !== 4'h0 || e_perr !== 1'b0 || o_perr !== 1'b0) begin
            n_fail++; $display("FAIL abort_reset: got busy=%b data=%h perr=%b/%b expected 0/0/0/0",
                               e_busy, e_data, e_perr, o_perr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(4'h9, 1'b0, 1'b1, 1);
        check_frame("after_abort_9", 4'h9, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (pulses != p0 + 1) begin
            n_fail++; $display("FAIL abort_pulses: got %0d expected 1", pulses - p0);
        end
    endtask

`ifdef PARITY_RX_ERRCNT_EN
    task automatic test_err_count;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(4'h0, 1'b1, 1'b0, 0);
        n_checks++;
        if (e_cnt !== 8'h01 || o_cnt !== 8'h01) begin
            n_fail++; $display("FAIL errcnt_both: got %h/%h expected 01/01", e_cnt, o_cnt);
        end
        for (int i = 0; i < 299; i++) send_frame(4'h0, 1'b1, 1'b1, 0);
        @(posedge clk); #1;
        n_checks++;
        if (e_cnt !== 8'hFF || o_cnt !== 8'h01) begin
            n_fail++; $display("FAIL errcnt_saturate: got %h/%h expected FF/01", e_cnt, o_cnt);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; bit_en = 1'b0; rxd = 1'b1;
        test_reset();
        test_idle();
        test_basic();
        test_back_to_back();
        test_abort();
`ifdef PARITY_RX_ERRCNT_EN
        test_err_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
